// File: rtl/road_scroll_integrator_pkg.sv
// rtl/road_scroll_integrator_pkg.sv - shared types and constants for the road scroll integrator
package road_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, FINISHED} road_state_t;

  localparam int SPEED_W       = 11;
  localparam int SCROLL_FP_MAX = 480 * 16;

  typedef logic signed [SPEED_W-1:0] speed_t;

endpackage

// File: rtl/road_scroll_integrator.sv
// rtl/road_scroll_integrator.sv - per-frame speed integration into wrapping scroll offset and distance
module road_scroll_integrator
  import road_pkg::*;
#(
  parameter int FIXED_POINT_MULTIPLIER = 16,
  parameter int SCREEN_HEIGHT          = 480,
  parameter int TRACK_LENGTH           = 20000
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        enable,
  input  logic        restart,
  input  speed_t      speed,
  output logic [9:0]  scrollY,
  output logic [15:0] distance,
  output logic        finish,
  output logic        running
);

  localparam int FRAC    = $clog2(FIXED_POINT_MULTIPLIER);
  localparam int POS_MAX = SCREEN_HEIGHT * FIXED_POINT_MULTIPLIER;
  localparam int POS_W   = $clog2(POS_MAX);
  localparam int DIST_W  = 16 + FRAC;

  localparam logic signed [POS_W:0]    POS_MAX_S  = (POS_W+1)'(POS_MAX);
  localparam logic signed [DIST_W+1:0] DIST_MAX_S = {2'b00, {DIST_W{1'b1}}};
  localparam logic [15:0]              TRACK_PX   = 16'(TRACK_LENGTH);

  road_state_t state, state_next;

  logic [POS_W-1:0]  pos_fp, pos_next;
  logic [DIST_W-1:0] dist_fp, dist_next;

  logic signed [POS_W:0]    pos_sum, spd_pos;
  logic signed [DIST_W+1:0] dist_sum, spd_dist;

  logic integrate;
  logic reached;

  assign integrate = (state == RUN) && startOfFrame && !restart;

  // Scroll wraps modulo the screen; |speed| is far below the modulus so one correction suffices.
  always_comb begin
    spd_pos = speed;
    pos_sum = $signed({1'b0, pos_fp}) + spd_pos;
    pos_next = POS_W'(pos_sum);
    if (pos_sum >= POS_MAX_S)
      pos_next = POS_W'(pos_sum - POS_MAX_S);
    else if (pos_sum < 0)
      pos_next = POS_W'(pos_sum + POS_MAX_S);
  end

  // Distance clamps at zero going backwards and at full scale going forwards.
  always_comb begin
    spd_dist = speed;
    dist_sum = $signed({2'b00, dist_fp}) + spd_dist;
    dist_next = DIST_W'(dist_sum);
    if (dist_sum < 0)
      dist_next = '0;
    else if (dist_sum > DIST_MAX_S)
      dist_next = {DIST_W{1'b1}};
  end

  assign reached = (dist_next[DIST_W-1:FRAC] >= TRACK_PX);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (enable) state_next = RUN;
      RUN: begin
        if (integrate && reached)
          state_next = FINISHED;
        else if (!enable)
          state_next = PAUSE;
      end
      PAUSE:    if (enable) state_next = RUN;
      FINISHED: state_next = FINISHED;
      default:  state_next = IDLE;
    endcase
    if (restart)
      state_next = IDLE;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pos_fp  <= '0;
      dist_fp <= '0;
    end else if (restart) begin
      pos_fp  <= '0;
      dist_fp <= '0;
    end else if (integrate) begin
      pos_fp  <= pos_next;
      dist_fp <= dist_next;
    end
  end

  assign scrollY  = 10'(pos_fp >> FRAC);
  assign distance = dist_fp[DIST_W-1:FRAC];
  assign finish   = (state == FINISHED);
  assign running  = (state == RUN);

endmodule

// File: tb/tb_road_scroll_integrator.sv
// tb/tb_road_scroll_integrator.sv - directed bench with a per-cycle reference model
module tb_road_scroll_integrator;

  localparam int TL   = 100;
  localparam int FPM  = 16;
  localparam int WRAP = 480 * FPM;
  localparam int DMAX = 1048575;

  logic              clk = 1'b0;
  logic              resetN;
  logic              startOfFrame;
  logic              enable;
  logic              restart;
  logic signed [10:0] speed;
  logic [9:0]        scrollY;
  logic [15:0]       distance;
  logic              finish;
  logic              running;

  int total = 0;
  int bad   = 0;
  bit started = 0;

  // Reference: modes 0 idle, 1 moving, 2 paused, 3 done.
  int m_pos, m_dist, m_mode;

  road_scroll_integrator #(.TRACK_LENGTH(TL)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
    .restart(restart), .speed(speed), .scrollY(scrollY), .distance(distance),
    .finish(finish), .running(running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge resetN) begin
    int p, d, md;
    if (!resetN) begin
      m_pos <= 0; m_dist <= 0; m_mode <= 0;
    end else if (restart) begin
      m_pos <= 0; m_dist <= 0; m_mode <= 0;
    end else begin
      p = m_pos; d = m_dist; md = m_mode;
      if (m_mode == 0 && enable) md = 1;
      else if (m_mode == 2 && enable) md = 1;
      else if (m_mode == 1) begin
        if (startOfFrame) begin
          p = ((m_pos + int'(speed)) % WRAP + WRAP) % WRAP;
          d = m_dist + int'(speed);
          if (d < 0) d = 0;
          if (d > DMAX) d = DMAX;
        end
        if (startOfFrame && d / FPM >= TL) md = 3;
        else if (!enable) md = 2;
      end
      m_pos <= p; m_dist <= d; m_mode <= md;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_scrollY", int'(scrollY), m_pos / FPM);
      chk("model_distance", int'(distance), m_dist / FPM);
      chk("model_finish", int'(finish), int'(m_mode == 3));
      chk("model_running", int'(running), int'(m_mode == 1));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic frame();
    @(posedge clk); #1 startOfFrame = 1'b1;
    @(posedge clk); #1 startOfFrame = 1'b0;
  endtask

  task automatic do_restart();
    @(posedge clk); #1 restart = 1'b1;
    @(posedge clk); #1 restart = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int sy, input int di, input int fi, input int ru);
    chk({tag, "_scrollY"}, int'(scrollY), sy);
    chk({tag, "_distance"}, int'(distance), di);
    chk({tag, "_finish"}, int'(finish), fi);
    chk({tag, "_running"}, int'(running), ru);
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; enable = 1'b0; restart = 1'b0; speed = '0;
    #12;
    expect_out("reset", 0, 0, 0, 0);
    started = 1;
    @(posedge clk); #1 resetN = 1'b1;

    enable = 1'b1; speed = 11'sd32;
    step();
    chk("enter_run", int'(running), 1);
    for (int i = 1; i <= 3; i++) begin
      frame();
      expect_out("fwd32", 2 * i, 2 * i, 0, 1);
    end

    do_restart();
    expect_out("restart1", 0, 0, 0, 0);
    speed = -11'sd16;
    frame();
    expect_out("back16", 479, 0, 0, 1);
    speed = 11'sd64;
    frame();
    expect_out("wrap_up", 3, 4, 0, 1);
    speed = -11'sd64;
    frame();
    expect_out("wrap_down", 479, 0, 0, 1);

    do_restart();
    speed = -11'sd100;
    for (int i = 0; i < 5; i++) frame();
    expect_out("reverse5", 448, 0, 0, 1);

    speed = 11'sd48;
    frame();
    expect_out("pre_pause", 451, 3, 0, 1);
    enable = 1'b0;
    step();
    for (int i = 0; i < 4; i++) frame();
    expect_out("paused", 451, 3, 0, 0);
    enable = 1'b1;
    frame();
    expect_out("resumed", 454, 6, 0, 1);

    @(posedge clk); #1 restart = 1'b1; startOfFrame = 1'b1;
    @(posedge clk); #1 restart = 1'b0; startOfFrame = 1'b0;
    expect_out("restart_sof", 0, 0, 0, 0);

    speed = 11'sd1023;
    frame();
    expect_out("fin_f1", 63, 63, 0, 1);
    frame();
    expect_out("fin_f2", 127, 127, 1, 0);
    frame();
    enable = 1'b0;
    frame();
    expect_out("fin_hold", 127, 127, 1, 0);

    enable = 1'b1;
    do_restart();
    speed = 11'sd16;
    frame();
    expect_out("pre_drop", 1, 1, 0, 1);
    @(posedge clk); #1 enable = 1'b0; startOfFrame = 1'b1;
    @(posedge clk); #1 startOfFrame = 1'b0;
    expect_out("drop_enable_sof", 2, 2, 0, 0);
    do_restart();
    @(posedge clk); #1 enable = 1'b1; startOfFrame = 1'b1;
    @(posedge clk); #1 startOfFrame = 1'b0;
    expect_out("idle_sof", 0, 0, 0, 1);

    frame();
    frame();
    expect_out("pre_async", 2, 2, 0, 1);
    @(posedge clk); #2 resetN = 1'b0;
    #1;
    expect_out("async_reset", 0, 0, 0, 0);
    @(posedge clk); #1 resetN = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/road_scroll_integrator.md
Name: road_scroll_integrator

Overview:
Consumes the signed 11-bit speed word produced by the game's speed/result generators, in the same signed [10:0] fixed-point format those blocks drive. Integrates that speed once per video frame into a wrapping vertical road-scroll offset and a forward distance counter. Raises a finish flag when the track length is covered. Sits between the speed generator and the road/background drawing blocks.

Parameters:
FIXED_POINT_MULTIPLIER, 16, sub-pixel scale of speed; must be 2^n
SCREEN_HEIGHT, 480, scroll wrap modulus in pixels
TRACK_LENGTH, 20000, distance in pixels at which finish asserts

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle strobe per frame
enable  in  1  level; high = run, low = pause
restart  in  1  one-cycle strobe; clears all state to IDLE
speed  in  11 signed  speed in 1/FIXED_POINT_MULTIPLIER pixel per frame; range -1024..1023
scrollY  out  10  road offset in pixels, 0..SCREEN_HEIGHT-1
distance  out  16  forward pixels travelled, saturating, never negative
finish  out  1  level; high in FINISHED state
running  out  1  high in RUN state

Behaviour:
- Reset (resetN=0, async): state=IDLE; internal pos_fp=0, dist_fp=0; scrollY=0, distance=0, finish=0, running=0.
- Internal state:
  - pos_fp: unsigned 13 bits, range 0..SCREEN_HEIGHT*FPM-1 = 0..7679.
  - dist_fp: unsigned 20 bits.
  - scrollY = pos_fp >> log2(FPM); distance = dist_fp >> log2(FPM), truncated to 16 bits.
- FSM states and transitions:
  - IDLE: enable=1 -> RUN.
  - RUN: enable=0 -> PAUSE; integration completes with dist >= TRACK_LENGTH -> FINISHED.
  - PAUSE: enable=1 -> RUN. All values hold.
  - FINISHED: holds all values; finish=1. Only restart or reset leaves it.
  - restart=1 in any state: next cycle state=IDLE, pos_fp=0, dist_fp=0. restart has priority over startOfFrame and enable in the same cycle.
- Integration happens only in RUN, on a cycle with startOfFrame=1. speed is sampled that cycle; outputs are registered and visible the next cycle (latency 1).
- Scroll update: s = pos_fp + sign-extended speed, computed at 14 bits signed.
  - s >= 7680 -> pos_fp = s - 7680.
  - s < 0 -> pos_fp = s + 7680.
  - Otherwise pos_fp = s.
  - |speed| <= 1024 < 7680, so a single correction always suffices.
- Distance update: d = dist_fp + speed.
  - d < 0 -> 0.
  - d > 2^20-1 -> 2^20-1.
- Finish check uses the updated value. If (d >> log2(FPM)) >= TRACK_LENGTH, the next state is FINISHED, and pos/dist take that frame's update.
- A startOfFrame in IDLE, PAUSE or FINISHED is ignored.
- An enable transition and startOfFrame in the same cycle: the current state decides. RUN with enable=0 and startOfFrame=1 still integrates, then moves to PAUSE. IDLE with enable=1 and startOfFrame=1 does not integrate.
- speed = 0 in RUN: no change, no wrap.

Decomposition:
- Package road_pkg holds:
  - FSM state enum {IDLE, RUN, PAUSE, FINISHED}.
  - Constants SPEED_W=11, SCROLL_FP_MAX = SCREEN_HEIGHT*FIXED_POINT_MULTIPLIER.
  - The speed typedef: logic signed [10:0].
- No sub-module; the FSM and two accumulators live in one module.

Test Plan:
- Reset then enable=1, speed=+32, 3 startOfFrame pulses -> scrollY 2,4,6 and distance 2,4,6, each 1 cycle after its pulse; running=1.
- pos at scrollY=479 (pos_fp=7664), speed=+64 -> pos_fp=48, scrollY=3. Then speed=-64 -> scrollY=479 (wrap-down).
- From reset, speed=-100, 5 frames -> distance stays 0; scrollY=(480*16-500)>>4=448.
- TRACK_LENGTH=100, speed=+1023 -> finish rises after the frame giving distance>=100 (frame 2: 2046>>4=127). Further frames do not change scrollY or distance.
- enable=0 mid-run, 4 frames -> values frozen, running=0. enable=1 -> integration resumes from the frozen values.
- restart and startOfFrame in the same cycle while in RUN -> next cycle all zero, IDLE; async resetN low mid-frame -> outputs 0 immediately, no clock needed.
